// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified IF/MEM memory-port arbiter.
// Holds the FSM state encoding, the grant identifiers and the default bus widths.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Memory-side bus of the arbiter: one request/ready handshake carrying a single
// read or byte-enabled write; the arbiter is master, the unified memory is slave.
interface unified_mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/arb_grant_sel.sv
// Grant decision taken in IDLE: data normally wins, but a fetch that has been
// waiting behind a data transaction is served next so IF cannot be starved.
module arb_grant_sel (
  input  logic if_req,
  input  logic d_req,
  input  logic flush_f,
  input  logic last_d,
  output logic grant_i,
  output logic grant_d
);

  assign grant_d = d_req & ~(last_d & if_req);
  assign grant_i = ~grant_d & if_req & ~flush_f;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one variable-latency memory
// port and returns results as one-cycle valid pulses with matching stall signals.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                flush_f,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                stall_f,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                stall_m,

  unified_mem_arbiter_if.master mbus
);

  state_e              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic                drop_q, drop_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;

  logic                grant_i, grant_d;
  gnt_e                gnt_sel;

  arb_grant_sel u_grant_sel (
    .if_req  (if_req),
    .d_req   (d_req),
    .flush_f (flush_f),
    .last_d  (last_d_q),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  assign gnt_sel = grant_d ? GNT_D : GNT_I;

  always_comb begin
    // NOTE: every _d starts as a copy of its _q so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    last_d_d    = last_d_q;
    drop_d      = drop_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_d || grant_i) begin
          state_d     = (gnt_sel == GNT_D) ? BUSY_D : BUSY_I;
          last_d_d    = (gnt_sel == GNT_D);
          mem_req_d   = 1'b1;
          mem_we_d    = (gnt_sel == GNT_D) && d_we;
          mem_addr_d  = (gnt_sel == GNT_D) ? d_addr : if_addr;
          mem_wdata_d = (gnt_sel == GNT_D) ? d_wdata : '0;
          mem_be_d    = (gnt_sel == GNT_D) ? d_be : '0;
        end
      end

      BUSY_I: begin
        // A flushed fetch still runs to completion on the memory; only its result is dropped.
        if (flush_f) begin
          drop_d = 1'b1;
        end
        if (mem_req_q && mbus.mem_ready) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = mbus.mem_rdata;
          if_valid_d = !(drop_q || flush_f);
          state_d    = RESP;
        end
      end

      BUSY_D: begin
        if (mem_req_q && mbus.mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            d_rdata_d = mbus.mem_rdata;
          end
          d_valid_d = 1'b1;
          state_d   = RESP;
        end
      end

      RESP: begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    if (rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign mbus.mem_req   = mem_req_q;
  assign mbus.mem_we    = mem_we_q;
  assign mbus.mem_addr  = mem_addr_q;
  assign mbus.mem_wdata = mem_wdata_q;
  assign mbus.mem_be    = mem_be_q;

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign d_valid  = d_valid_q;

  // A redirect arriving in the response cycle itself must still kill the fetch pulse.
  assign if_valid = if_valid_q & ~flush_f;

  assign stall_f = if_req & ~if_valid;
  assign stall_m = d_req & ~d_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a latency-programmable memory model,
// a scoreboard of expected grants and read results, and a separate monitor.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush_f;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        stall_f;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall_m;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mbus ();

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .flush_f  (flush_f),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .stall_f  (stall_f),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .stall_m  (stall_m),
    .mbus     (mbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } grant_t;

  grant_t      exp_g[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  grant_t      cur_g;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_data [logic [31:0]];
  int          lat;
  bit          tie_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected/missing event, expected clean handshake", name);
  endtask

  function automatic grant_t mk_g(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be);
    grant_t g;
    g.we = we; g.addr = addr; g.wdata = wdata; g.be = be;
    return g;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] addr);
    return mem_data.exists(addr) ? mem_data[addr] : 32'h0;
  endfunction

  // Memory model: answers lat cycles after mem_req rises, or every cycle when tied ready.
  initial begin
    int cnt;
    cnt = 0;
    mbus.mem_ready = 1'b0;
    mbus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (tie_ready) begin
        mbus.mem_ready = 1'b1;
        mbus.mem_rdata = rd(mbus.mem_addr);
      end else if (mbus.mem_req && !rst) begin
        if (cnt >= lat) begin
          mbus.mem_ready = 1'b1;
          mbus.mem_rdata = mbus.mem_we ? 32'h0 : rd(mbus.mem_addr);
          cnt = 0;
        end else begin
          mbus.mem_ready = 1'b0;
          cnt++;
        end
      end else begin
        mbus.mem_ready = 1'b0;
        cnt = 0;
      end
      if (mbus.mem_req && mbus.mem_ready && mbus.mem_we) begin
        logic [31:0] w;
        w = rd(mbus.mem_addr);
        for (int b = 0; b < 4; b++)
          if (mbus.mem_be[b]) w[8*b +: 8] = mbus.mem_wdata[8*b +: 8];
        mem_data[mbus.mem_addr] = w;
      end
    end
  end

  // Monitor: grants and response pulses are matched against the scoreboard queues.
  initial begin
    logic        req_prev;
    logic [31:0] e;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mbus.mem_req) begin
          if (!req_prev) begin
            if (exp_g.size() == 0) fail_now("grant_unexpected");
            else cur_g = exp_g.pop_front();
          end
          check("grant_we",    mbus.mem_we,    cur_g.we);
          check("grant_addr",  mbus.mem_addr,  cur_g.addr);
          check("grant_wdata", mbus.mem_wdata, cur_g.wdata);
          check("grant_be",    mbus.mem_be,    cur_g.be);
        end
        if (if_valid) begin
          if (exp_i.size() == 0) fail_now("if_valid_unexpected");
          else begin e = exp_i.pop_front(); check("if_rdata", if_rdata, e); end
        end
        if (d_valid) begin
          if (exp_d.size() == 0) fail_now("d_valid_unexpected");
          else begin e = exp_d.pop_front(); check("d_rdata", d_rdata, e); end
        end
      end
      req_prev = mbus.mem_req;
    end
  end

  task automatic wait_mem_req(input logic level, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mbus.mem_req !== level && n < 40);
    if (mbus.mem_req !== level) fail_now(name);
  endtask

  // Called at posedge+1; returns at posedge+1 of the first IDLE cycle after the pulse.
  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata,
                          input int exp_lat, input bit hold);
    int n;
    bit seen;
    exp_d.push_back(exp_rdata);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (d_valid) seen = 1'b1;
      else if (n == 1) check("stall_m_wait", stall_m, 1);
    end
    if (!seen) fail_now("d_valid_timeout");
    else begin
      check("stall_m_pulse", stall_m, 0);
      if (exp_lat != 0) check("d_latency", n, exp_lat);
    end
    @(posedge clk); #1;
    if (!hold) begin d_req = 1'b0; d_we = 1'b0; end
  endtask

  task automatic i_fetch(input logic [31:0] addr, input logic [31:0] exp_rdata,
                         input int exp_lat, input bit hold);
    int n;
    bit seen;
    exp_i.push_back(exp_rdata);
    if_req = 1'b1; if_addr = addr;
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (if_valid) seen = 1'b1;
      else if (n == 1) check("stall_f_wait", stall_f, 1);
    end
    if (!seen) fail_now("if_valid_timeout");
    else begin
      check("stall_f_pulse", stall_f, 0);
      if (exp_lat != 0) check("if_latency", n, exp_lat);
    end
    @(posedge clk); #1;
    if (!hold) if_req = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req",   mbus.mem_req,   0);
    check("rst_mem_we",    mbus.mem_we,    0);
    check("rst_mem_addr",  mbus.mem_addr,  0);
    check("rst_mem_wdata", mbus.mem_wdata, 0);
    check("rst_mem_be",    mbus.mem_be,    0);
    check("rst_if_rdata",  if_rdata,       0);
    check("rst_d_rdata",   d_rdata,        0);
    check("rst_if_valid",  if_valid,       0);
    check("rst_d_valid",   d_valid,        0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; flush_f = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    tie_ready = 1'b0; lat = 0;

    mem_data[32'h100] = 32'hDEADBEEF;
    mem_data[32'h300] = 32'h0000A1A1;
    mem_data[32'h304] = 32'h0000A2A2;
    mem_data[32'h010] = 32'h0000B2B2;
    mem_data[32'h040] = 32'hBAD00040;
    mem_data[32'h044] = 32'hBAD00044;
    mem_data[32'h080] = 32'h00000013;
    mem_data[32'h000] = 32'h00100093;
    mem_data[32'h004] = 32'h00200113;
    mem_data[32'h008] = 32'h00300193;
    mem_data[32'h00C] = 32'h00400213;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    check("rst_stall_f", stall_f, 0);
    check("rst_stall_m", stall_m, 0);
    @(posedge clk); #1;

    // Single load, ready 3 cycles after mem_req: pulse lands 5 cycles after the request cycle.
    lat = 3;
    exp_g.push_back(mk_g(1'b0, 32'h100, 32'h0, 4'h0));
    d_access(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 6, 1'b0);

    // Store: d_rdata keeps the previous load value.
    lat = 2;
    exp_g.push_back(mk_g(1'b1, 32'h200, 32'h12345678, 4'hF));
    d_access(1'b1, 32'h200, 32'h12345678, 4'hF, 32'hDEADBEEF, 5, 1'b0);
    check("store_mem", rd(32'h200), 32'h12345678);

    // Flush while the fetch is in flight.
    lat = 4;
    exp_g.push_back(mk_g(1'b0, 32'h040, 32'h0, 4'h0));
    exp_g.push_back(mk_g(1'b0, 32'h044, 32'h0, 4'h0));
    exp_g.push_back(mk_g(1'b0, 32'h080, 32'h0, 4'h0));
    if_req = 1'b1; if_addr = 32'h040;
    wait_mem_req(1'b1, "flush_busy_grant");
    @(posedge clk); #1 flush_f = 1'b1; if_req = 1'b0;
    @(posedge clk); #1 flush_f = 1'b0;
    wait_mem_req(1'b0, "flush_busy_complete");
    @(posedge clk); #1;

    // Flush in the response cycle, then flush in IDLE blocking one grant.
    lat = 0;
    if_req = 1'b1; if_addr = 32'h044;
    wait_mem_req(1'b1, "flush_resp_grant");
    @(posedge clk); #1 flush_f = 1'b1; if_req = 1'b0;
    @(negedge clk);
    check("flush_resp_if_valid", if_valid, 0);
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h080; lat = 1;
    @(posedge clk); #1 flush_f = 1'b0;
    @(negedge clk);
    check("flush_idle_no_grant", mbus.mem_req, 0);
    i_fetch(32'h080, 32'h00000013, 3, 1'b0);

    // Contention: data, then the waiting fetch, then data again.
    lat = 1;
    exp_g.push_back(mk_g(1'b0, 32'h300, 32'h0, 4'h0));
    exp_g.push_back(mk_g(1'b0, 32'h010, 32'h0, 4'h0));
    exp_g.push_back(mk_g(1'b0, 32'h304, 32'h0, 4'h0));
    fork
      begin
        d_access(1'b0, 32'h300, 32'h0, 4'h0, 32'h0000A1A1, 0, 1'b1);
        d_access(1'b0, 32'h304, 32'h0, 4'h0, 32'h0000A2A2, 0, 1'b0);
      end
      i_fetch(32'h010, 32'h0000B2B2, 0, 1'b0);
    join

    // Reset while a load is outstanding.
    lat = 5;
    exp_g.push_back(mk_g(1'b0, 32'h500, 32'h0, 4'h0));
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_wdata = 32'h0; d_be = 4'h0;
    wait_mem_req(1'b1, "rst_busy_grant");
    @(posedge clk); #1 rst = 1'b1; d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_valid) pulses++;
    end
    check("rst_no_d_valid", pulses, 0);

    // Zero-wait memory: back-to-back fetches every 3 cycles.
    @(posedge clk); #1 tie_ready = 1'b1;
    @(posedge clk); #1;
    exp_g.push_back(mk_g(1'b0, 32'h000, 32'h0, 4'h0));
    exp_g.push_back(mk_g(1'b0, 32'h004, 32'h0, 4'h0));
    exp_g.push_back(mk_g(1'b0, 32'h008, 32'h0, 4'h0));
    exp_g.push_back(mk_g(1'b0, 32'h00C, 32'h0, 4'h0));
    i_fetch(32'h000, 32'h00100093, 3, 1'b1);
    i_fetch(32'h004, 32'h00200113, 3, 1'b1);
    i_fetch(32'h008, 32'h00300193, 3, 1'b1);
    i_fetch(32'h00C, 32'h00400213, 3, 1'b0);
    tie_ready = 1'b0;

    repeat (5) @(posedge clk);
    check("left_grants", exp_g.size(), 0);
    check("left_if",     exp_i.size(), 0);
    check("left_d",      exp_d.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequences a single shared memory port between the instruction-fetch (IF) stage and the data-access (MEM) stage of the five-stage pipeline. It sits between the pipeline and a unified instruction/data memory with variable latency. It serialises requests through a small state machine and returns read data on one-cycle valid pulses. It generates the IF and MEM stall signals consumed by the hazard logic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte-enable width = DATA_W/8)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_valid or flush_f
- if_addr  in  ADDR_W  fetch address (PC)
- flush_f  in  1  discard pending/in-flight fetch result (taken branch/jump)
- if_rdata  out  DATA_W  fetched instruction, registered
- if_valid  out  1  one-cycle pulse: if_rdata valid
- stall_f  out  1  if_req & ~if_valid
- d_req  in  1  data request, held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_rdata  out  DATA_W  load data, registered
- d_valid  out  1  one-cycle pulse: data access complete
- stall_m  out  1  d_req & ~d_valid
- mem_req, mem_we  out  1  memory request / write strobe
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_be  out  DATA_W/8
- mem_ready  in  1  memory completes transaction this cycle (when mem_req=1)
- mem_rdata  in  DATA_W  read data, valid with mem_ready

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP. Requests sampled only in IDLE.
- IDLE: if d_req and not (last_d and if_req) -> BUSY_D; else if if_req and not flush_f -> BUSY_I; else stay.
- Priority: data wins; fairness rule: after a data transaction (last_d=1), a pending if_req is granted next even if d_req=1. last_d cleared on any IF grant.
- On grant: mem_req=1, mem_* registered from granting requester; held stable until mem_ready.
- BUSY_x with mem_ready: mem_req, mem_we -> 0; loads/fetches capture mem_rdata into d_rdata/if_rdata; stores leave d_rdata unchanged; -> RESP.
- RESP: pulse d_valid or if_valid for the granted requester; -> IDLE.
- Flush: flush_f in BUSY_I sets drop flag; transaction still completes on memory (no abort); if_valid suppressed in RESP. flush_f in RESP of IF also suppresses if_valid. flush_f in IDLE blocks IF grant that cycle only. Drop flag cleared on leaving RESP.
- flush_f has no effect on data transactions.

## Timing
- Reset: state IDLE, last_d=0, drop=0; mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, d_rdata, if_valid, d_valid all 0.
- Minimum latency: request seen in IDLE at t, mem_req at t+1, mem_ready at t+1 earliest, valid pulse t+2, IDLE t+3 (new grant issues at t+4).
- mem_ready ignored when mem_req=0.
- Requester must keep req/addr/data stable until its valid pulse; it may change them in the cycle after the pulse, which is also the first IDLE sampling cycle.
- stall_f/stall_m combinational from inputs and the registered valid pulses; no other combinational path from mem_* inputs to outputs.
- Reset mid-transaction: mem_req drops the cycle after rst; the memory abandons the transaction; no valid pulse issued.

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUSY_I, BUSY_D, RESP), grant id constants (GNT_I, GNT_D), default widths.
- One combinational sub-module arb_grant_sel: inputs if_req, d_req, flush_f, last_d; outputs grant_i, grant_d. The FSM, registers and response muxing stay in the top.

## Test plan
- Single load: d_req=1, d_addr=0x100, memory ready 3 cycles after mem_req, mem_rdata=0xDEADBEEF -> d_valid pulse one cycle after ready, d_rdata=0xDEADBEEF, stall_m high until the pulse.
- Store: d_we=1, d_addr=0x200, d_wdata=0x12345678, d_be=0xF -> mem_we=1 with these values held until mem_ready; d_valid pulse; d_rdata unchanged.
- Contention: if_req and d_req both high in IDLE -> data granted first, then IF granted next while d_req stays high; the third grant goes back to data.
- Flush in flight: fetch to 0x40 in BUSY_I, flush_f pulse, ready later -> no if_valid; the next fetch at 0x80 returns correct data.
- Reset in BUSY_D: rst for 1 cycle -> all outputs 0 the next cycle, state IDLE, no d_valid.
- Zero-wait memory: mem_ready tied 1 -> back-to-back fetches complete every 3 cycles with a correct if_rdata sequence.
